div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle 32-bit integer divider serving the execute stage as a request/response responder.
//  EX raises start_i with both operands and holds them until ready_o; the divider then returns {remainder, quotient}.
//  EX stalls the pipeline through the ctrl stall request while ready_o is low.
//  Implements DIV/DIVU (HI <= remainder, LO <= quotient); restoring radix-2 algorithm, one quotient bit per cycle.
// PARAMETERS
//  DATA_W   32   operand width; iteration count = DATA_W
//  CNT_W    6    iteration counter width, >= clog2(DATA_W+1)
// PORTS
//  clk           in   1         clock; all state updates on posedge
//  rst           in   1         synchronous, active-high reset (`RstEnable = 1'b1)
//  signed_div_i  in   1         1 = signed DIV, 0 = unsigned DIVU
//  opdata1_i     in   DATA_W    dividend
//  opdata2_i     in   DATA_W    divisor
//  start_i       in   1         request; held high by EX until ready_o seen
//  annul_i       in   1         flush/exception: abort current division
//  result_o      out  2*DATA_W  {remainder, quotient}; valid only while ready_o=1
//  ready_o       out  1         result valid
// BEHAVIOUR
//  Reset: state=DivFree, ready_o=0, result_o=0, counter=0; reset mid-operation discards the work.
//  States: DivFree, DivByZero, DivOn, DivEnd; encodings come from the shared defines.
//  DivFree: if start_i & !annul_i, then: divisor==0 -> DivByZero; otherwise latch |operands|, cnt=0 -> DivOn.
//    |x| = two's-complement negation when signed_div_i & x[MSB]; otherwise x unchanged. Latch signs s1=op1 MSB, s2=op2 MSB.
//  DivByZero: next edge -> DivEnd with result 0.
//  DivOn: each edge computes {rem,q} <- shift-subtract step; cnt++. After DATA_W steps -> DivEnd.
//    In DivEnd: if signed, quotient negated when s1^s2, remainder negated when s1.
//  DivOn abort: annul_i=1 or start_i=0 on any edge -> DivFree; ready_o stays 0; nothing is written.
//  DivEnd: ready_o=1 and result_o registered. Stays until start_i=0; on that edge -> DivFree, ready_o<=0, result_o<=0.
//  Latency: start sampled on edge 1 -> ready_o high after edge DATA_W+2 (34). Divide-by-zero -> high after edge 2.
//  Operands change while busy: ignored (latched at start). start_i high in DivFree with annul_i=1: stay DivFree.
//  Overflow: signed 0x80000000 / -1 -> quotient 0x80000000, remainder 0 (natural wrap, no flag).
//  Width: remainder datapath is DATA_W+1 bits for the trial subtraction; outputs truncated to DATA_W each.
// CONFIGURATION
//  DIV_ZERO_FLAG_EN defined: extra output div_zero_o (1 bit). It is set with ready_o when the divisor was 0 and cleared
//    with ready_o; it is 0 at reset. EX uses it to raise a trap.
//  Undefined: no port; divide-by-zero silently yields result_o=0 with normal ready_o timing.
// STRUCTURE
//  Shared defines.v: DivFree/DivByZero/DivOn/DivEnd encodings, DivResultReady/NotReady, DivStart/DivStop,
//    ZeroWord, RstEnable.
//  Sub-module div_abs: combinational conditional negation (value, enable) -> value. Used for operand absolute
//    values and result sign fix-up.
//  Everything else lives in div_unit: FSM, counter, and shift/subtract datapath.
// TESTING
//  DIVU 100/7, start held -> after edge 34: ready_o=1, result_o={32'd2, 32'd14}; start_i dropped -> ready_o=0 next edge.
//  DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
//  Divide by zero 5/0 -> ready_o after edge 2, result_o=0; with DIV_ZERO_FLAG_EN, div_zero_o=1 alongside.
//  annul_i pulsed at iteration 10 -> ready_o never rises, state DivFree; next DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
//  rst asserted at iteration 20 -> next edge all outputs 0; a new 9/3 request completes normally -> {0, 3}.
//  Operands changed mid-division -> result reflects the operands latched at start.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, ready/start levels and reset polarity.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic RstEnable         = 1'b1;

endpackage

// File: rtl/div_unit_abs.sv
// Conditional two's-complement negation, used for operand magnitudes and the result sign fix-up.
module div_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_value,
    input  logic         i_neg_en,
    output logic [W-1:0] o_value
);

    assign o_value = i_neg_en ? (~i_value + W'(1)) : i_value;

endmodule

// File: rtl/div_unit.sv
// Restoring radix-2 DIV/DIVU unit, one quotient bit per cycle, result = {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o, raised alongside ready_o for a zero divisor.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                  div_zero_o
`endif
);

    div_state_e            r_state;
    div_state_e            w_state_next;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_quo;
    logic [DATA_W-1:0]     r_divisor;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_signed;
    logic                  r_s1;
    logic                  r_s2;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic [DATA_W-1:0]     w_op1_abs;
    logic [DATA_W-1:0]     w_op2_abs;
    logic [DATA_W-1:0]     w_quo_fix;
    logic [DATA_W-1:0]     w_rem_fix;
    logic [DATA_W:0]       w_shift;
    logic [DATA_W:0]       w_trial;
    logic                  w_start_go;
    logic                  w_abort;
    logic                  w_cnt_done;
    logic                  w_div_zero;

    div_abs #(.W(DATA_W)) u_abs_op1 (
        .i_value (opdata1_i),
        .i_neg_en(signed_div_i & opdata1_i[DATA_W-1]),
        .o_value (w_op1_abs)
    );

    div_abs #(.W(DATA_W)) u_abs_op2 (
        .i_value (opdata2_i),
        .i_neg_en(signed_div_i & opdata2_i[DATA_W-1]),
        .o_value (w_op2_abs)
    );

    div_abs #(.W(DATA_W)) u_fix_quo (
        .i_value (r_quo),
        .i_neg_en(r_signed & (r_s1 ^ r_s2)),
        .o_value (w_quo_fix)
    );

    div_abs #(.W(DATA_W)) u_fix_rem (
        .i_value (r_rem),
        .i_neg_en(r_signed & r_s1),
        .o_value (w_rem_fix)
    );

    // Trial subtraction is one bit wider; its MSB is the borrow that decides the quotient bit.
    assign w_shift    = {r_rem, r_quo[DATA_W-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_start_go = (start_i == DivStart) && !annul_i;
    assign w_abort    = annul_i || (start_i == DivStop);
    assign w_cnt_done = (r_cnt == CNT_W'(DATA_W));
    assign w_div_zero = (opdata2_i == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DivFree: begin
                if (w_start_go) begin
                    w_state_next = w_div_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: w_state_next = DivEnd;
            DivOn: begin
                if (w_abort) begin
                    w_state_next = DivFree;
                end else if (w_cnt_done) begin
                    w_state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_next = DivFree;
                end
            end
            default: w_state_next = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state   <= DivFree;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                DivFree: begin
                    if (w_start_go && !w_div_zero) begin
                        r_rem     <= '0;
                        r_quo     <= w_op1_abs;
                        r_divisor <= w_op2_abs;
                        r_cnt     <= '0;
                        r_signed  <= signed_div_i;
                        r_s1      <= opdata1_i[DATA_W-1];
                        r_s2      <= opdata2_i[DATA_W-1];
                    end
                end
                DivByZero: begin
                    r_result <= '0;
                    r_ready  <= DivResultReady;
                end
                DivOn: begin
                    if (!w_abort) begin
                        if (w_cnt_done) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= DivResultReady;
                        end else begin
                            r_rem <= w_trial[DATA_W] ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
                            r_quo <= {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        r_result <= '0;
                        r_ready  <= DivResultNotReady;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic r_div_zero;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_div_zero <= 1'b0;
        end else if (r_state == DivByZero) begin
            r_div_zero <= 1'b1;
        end else if (r_state == DivEnd && start_i == DivStop) begin
            r_div_zero <= 1'b0;
        end
    end

    assign div_zero_o = r_div_zero;
`endif

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands against an arithmetic reference.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o  (div_zero_o)
`endif
    );

    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        int          q;
        int          r;
        logic [31:0] qv;
        logic [31:0] rv;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv, qv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a request and waits (bounded) for ready_o; lat is the edge count from the start edge.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int lat);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        lat          = 0;
        do begin
            tick();
            lat++;
        end while (!ready_o && lat < 100);
    endtask

    task automatic stop_div();
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();
        tick();
        n_tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        end else $display("[TB] reset ok");
`ifdef DIV_ZERO_FLAG_EN
        n_tests++;
        if (div_zero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flag: div_zero=%b, required 0", div_zero_o);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic        ts[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] ta[3] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] tb[3] = '{32'd7, 32'd2, 32'hFFFF_FFFF};
        logic [63:0] te[3] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_div(ts[i], ta[i], tb[i], lat);
            n_tests++;
            if (lat !== 34 || result_o !== te[i]) begin
                n_fail++;
                $display("FAIL directed%0d: lat=%0d result=%h, required lat=34 result=%h", i, lat, result_o, te[i]);
            end else $display("[TB] directed%0d %h/%h -> %h", i, ta[i], tb[i], result_o);
            stop_div();
            n_tests++;
            if (ready_o !== 1'b0 || result_o !== 64'd0) begin
                n_fail++;
                $display("FAIL directed%0d_release: ready=%b result=%h, required 0/0", i, ready_o, result_o);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_div(1'b0, 32'd5, 32'd0, lat);
        n_tests++;
        if (lat !== 2 || result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL div_zero: lat=%0d result=%h, required lat=2 result=0", lat, result_o);
        end else $display("[TB] div_zero 5/0 -> %h after %0d edges", result_o, lat);
`ifdef DIV_ZERO_FLAG_EN
        n_tests++;
        if (div_zero_o !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero_flag: div_zero=%b, required 1", div_zero_o);
        end
`endif
        stop_div();
        n_tests++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL div_zero_release: ready=%b, required 0", ready_o);
        end
`ifdef DIV_ZERO_FLAG_EN
        n_tests++;
        if (div_zero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL div_zero_flag_clear: div_zero=%b, required 0", div_zero_o);
        end
`endif
    endtask

    task automatic test_annul();
        int lat;
        int highs;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1234567;
        opdata2_i    = 32'd89;
        start_i      = 1'b1;
        repeat (11) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o !== 1'b0) highs++;
        end
        n_tests++;
        if (highs !== 0) begin
            n_fail++;
            $display("FAIL annul: ready high on %0d cycles, required 0", highs);
        end else $display("[TB] annul: no result produced");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat);
        n_tests++;
        if (lat !== 34 || result_o !== {32'd0, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL annul_next: lat=%0d result=%h, required lat=34 result=00000000ffffffff", lat, result_o);
        end else $display("[TB] after annul FFFFFFFF/1 -> %h", result_o);
        stop_div();
    endtask

    task automatic test_reset_mid();
        int lat;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77777;
        opdata2_i    = 32'd13;
        start_i      = 1'b1;
        repeat (21) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        n_tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b result=%h, required 0/0", ready_o, result_o);
        end else $display("[TB] reset mid-operation cleared outputs");
        rst = 1'b0;
        tick();
        run_div(1'b0, 32'd9, 32'd3, lat);
        n_tests++;
        if (lat !== 34 || result_o !== {32'd0, 32'd3}) begin
            n_fail++;
            $display("FAIL reset_mid_next: lat=%0d result=%h, required lat=34 result=0000000000000003", lat, result_o);
        end else $display("[TB] after reset 9/3 -> %h", result_o);
        stop_div();
    endtask

    task automatic test_operand_change();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        a = $urandom();
        b = $urandom_range(1, 1000);
        exp = model_div(1'b1, a, b);
        signed_div_i = 1'b1;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 5) begin
                opdata1_i    = $urandom();
                opdata2_i    = $urandom();
                signed_div_i = 1'b0;
            end
        end while (!ready_o && lat < 100);
        n_tests++;
        if (lat !== 34 || result_o !== exp) begin
            n_fail++;
            $display("FAIL operand_change: lat=%0d result=%h, required lat=34 result=%h", lat, result_o, exp);
        end else $display("[TB] operand change ignored %h/%h -> %h", a, b, result_o);
        stop_div();
    endtask

    task automatic test_back_to_back();
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        int          sel;
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom();
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 32'd0;
            else if (sel < 5)  b = $urandom_range(1, 255);
            else if (sel == 5) b = 32'hFFFF_FFFF;
            else               b = $urandom();
            if (sel == 5 && i % 2 == 0) a = 32'h8000_0000;
            if (sel == 6) a = 32'd0;
            exp     = model_div(sgn, a, b);
            exp_lat = (b == 32'd0) ? 2 : 34;
            run_div(sgn, a, b, lat);
            n_tests++;
            if (lat !== exp_lat || result_o !== exp) begin
                n_fail++;
                $display("FAIL rand%0d: s=%b %h/%h lat=%0d result=%h, required lat=%0d result=%h",
                         i, sgn, a, b, lat, result_o, exp_lat, exp);
            end else $display("[TB] rand%0d s=%b %h/%h -> %h", i, sgn, a, b, result_o);
`ifdef DIV_ZERO_FLAG_EN
            n_tests++;
            if (div_zero_o !== (b == 32'd0)) begin
                n_fail++;
                $display("FAIL rand%0d_flag: div_zero=%b, required %b", i, div_zero_o, (b == 32'd0));
            end
`endif
            stop_div();
            n_tests++;
            if (ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_release: ready=%b, required 0", i, ready_o);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        test_reset();
        test_directed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_operand_change();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
